// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling tick constants.
// Also used by the transmitter and the baud-tick generator.
package uart_pkg;

    localparam int N_TICKS        = 16;
    localparam int MID_START_TICK = 7;
    localparam int LAST_TICK      = 15;

    // One-hot so each state decode is a single flop bit.
    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        START = 5'b00010,
        RECV  = 5'b00100,
        STOP  = 5'b01000,
        BREAK = 5'b10000
    } uart_rx_state_e;

    // Tick count at the middle of the last stop bit, measured from mid data bit.
    function automatic int stop_last_tick(input int nb_stop);
        return nb_stop * N_TICKS - 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-side and host-side signals of the UART receiver.
// master = receiver, slave = line driver / host that consumes received bytes.
interface uart_rx_if #(
    parameter int NB_DATA = 8
);

    logic               i_tick;
    logic               i_rx;
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done;
    logic               o_frame_error;
    logic               o_busy;

    modport master (
        input  i_tick,
        input  i_rx,
        output o_data,
        output o_rx_done,
        output o_frame_error,
        output o_busy
    );

    modport slave (
        output i_tick,
        output i_rx,
        input  o_data,
        input  o_rx_done,
        input  o_frame_error,
        input  o_busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line.
// Resets to all ones so an idle-high line never looks like a start bit.
module uart_rx_sync #(
    parameter int NB_SYNC = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic [NB_SYNC-1:0] sync_q;
    logic [NB_SYNC-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[NB_SYNC-2:0], i_async};
    end

    // NOTE: non-blocking assignment so every stage takes its neighbour's old value in the same edge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_sync = sync_q[NB_SYNC-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling: mid-bit start validation, LSB-first data capture,
// stop-bit check, one-cycle done / framing-error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA         = 8,
    parameter int NB_STOP         = 1,
    parameter int BAUD_RATE       = 9600,
    parameter int SYS_CLOCK       = 100000000,
    parameter int NB_TICK_COUNTER = $clog2(NB_STOP * 16),
    parameter int NB_DATA_COUNTER = $clog2(NB_DATA) + 1
) (
    input  logic     i_clock,
    input  logic     i_reset,
    uart_rx_if.master bus
);

    localparam logic [NB_TICK_COUNTER-1:0] MID_TICK   = NB_TICK_COUNTER'(MID_START_TICK);
    localparam logic [NB_TICK_COUNTER-1:0] BIT_TICK   = NB_TICK_COUNTER'(LAST_TICK);
    localparam logic [NB_TICK_COUNTER-1:0] STOP_TICK  = NB_TICK_COUNTER'(stop_last_tick(NB_STOP));
    localparam logic [NB_TICK_COUNTER-1:0] TICK_ONE   = NB_TICK_COUNTER'(1);
    localparam logic [NB_DATA_COUNTER-1:0] LAST_BIT   = NB_DATA_COUNTER'(NB_DATA - 1);
    localparam logic [NB_DATA_COUNTER-1:0] BIT_ONE    = NB_DATA_COUNTER'(1);

    generate
        if (NB_STOP != 1 && NB_STOP != 2) begin : g_bad_stop
            $error("uart_rx: NB_STOP must be 1 or 2");
        end
        if (NB_DATA < 2) begin : g_bad_data
            $error("uart_rx: NB_DATA must be at least 2");
        end
        if ((2 ** NB_TICK_COUNTER) < NB_STOP * N_TICKS) begin : g_bad_tick_width
            $error("uart_rx: NB_TICK_COUNTER too narrow for the stop interval");
        end
        if (SYS_CLOCK < BAUD_RATE * N_TICKS) begin : g_bad_clock
            $error("uart_rx: system clock too slow for 16x oversampling at BAUD_RATE");
        end
    endgenerate

    logic rx_s;

    uart_rx_sync #(
        .NB_SYNC (2)
    ) u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (bus.i_rx),
        .o_sync  (rx_s)
    );

    uart_rx_state_e              state_q,       state_d;
    logic [NB_TICK_COUNTER-1:0]  tick_cnt_q,    tick_cnt_d;
    logic [NB_DATA_COUNTER-1:0]  bit_cnt_q,     bit_cnt_d;
    logic [NB_DATA-1:0]          shift_q,       shift_d;
    logic [NB_DATA-1:0]          data_q,        data_d;
    logic                        rx_done_q,     rx_done_d;
    logic                        frame_error_q, frame_error_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_d        = data_q;
        rx_done_d     = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end

            START: begin
                if (bus.i_tick) begin
                    if (tick_cnt_q == MID_TICK) begin
                        tick_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = RECV;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
            end

            RECV: begin
                if (bus.i_tick) begin
                    if (tick_cnt_q == BIT_TICK) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[NB_DATA-1:1]};
                        bit_cnt_d  = bit_cnt_q + BIT_ONE;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
            end

            STOP: begin
                // Sample lands at the middle of the last stop bit.
                if (bus.i_tick) begin
                    if (tick_cnt_q == STOP_TICK) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            data_d    = shift_q;
                            rx_done_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            frame_error_d = 1'b1;
                            state_d       = BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
            end

            BREAK: begin
                // A line held low must return high before a new start bit counts.
                if (rx_s) begin
                    state_d    = IDLE;
                    tick_cnt_d = '0;
                end
            end

            default: begin
                state_d    = IDLE;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            rx_done_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            rx_done_q     <= rx_done_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign bus.o_data        = data_q;
    assign bus.o_rx_done     = rx_done_q;
    assign bus.o_frame_error = frame_error_q;
    assign bus.o_busy        = (state_q != IDLE);

endmodule
